// File: rtl/mem_rf_imm_pkg.sv
// Shared types for the operand source mux:
// source-select encoding and collector FSM states.
package mem_rf_imm_pkg;

  typedef enum logic [1:0] {
    SRC_RF  = 2'b00,
    SRC_MEM = 2'b01,
    SRC_IMM = 2'b10
  } src_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    HOLD     = 2'b10
  } state_e;

endpackage

// File: rtl/operand_source_mux.sv
// Operand collector: picks RF, IMM or a memory read,
// waits for memory with timeout, holds result until consumed.
module operand_source_mux
  import mem_rf_imm_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MUX_SELECT_BITS = 2,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [MUX_SELECT_BITS-1:0] req_select,
  output logic                       req_ready,
  input  logic [DATA_WIDTH-1:0]      rf_data,
  input  logic [DATA_WIDTH-1:0]      imm_data,
  output logic                       mem_rd_en,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data,
  input  logic                       mem_rd_valid,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_err,
  input  logic                       out_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [MUX_SELECT_BITS-1:0] SEL_MEM =
    MUX_SELECT_BITS'(SRC_MEM);
  localparam logic [MUX_SELECT_BITS-1:0] SEL_IMM =
    MUX_SELECT_BITS'(SRC_IMM);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_err_q, out_err_d;
  logic                    out_valid_q, out_valid_d;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic                    sel_mem, sel_imm;

  assign sel_mem   = (req_select == SEL_MEM);
  assign sel_imm   = (req_select == SEL_IMM);
  assign req_ready = (state_q == IDLE);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign mem_rd_en = mem_rd_en_q;

  // Next-state and next-output decode for the collector
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    mem_rd_en_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            sel_mem: begin
              state_d     = WAIT_MEM;
              mem_rd_en_d = 1'b1;
              cnt_d       = CNT_ONE;
            end
            sel_imm: begin
              state_d     = HOLD;
              out_data_d  = imm_data;
              out_err_d   = 1'b0;
              out_valid_d = 1'b1;
            end
            default: begin
              state_d     = HOLD;
              out_data_d  = rf_data;
              out_err_d   = 1'b0;
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      WAIT_MEM: begin
        if (mem_rd_valid) begin
          state_d     = HOLD;
          out_data_d  = mem_rd_data;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = HOLD;
          out_data_d  = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      mem_rd_en_q <= mem_rd_en_d;
    end
  end

endmodule
